syn_up_mod: RTL and testbench



---
 rtl/syn_up_mod.sv | 63 ++++++
 tb/tb_syn_up_mod.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/syn_up_mod.sv
// Synchronous binary up counter with programmable terminal value,
// parallel load, count enable, cascade carry and one-shot done flag.
module syn_up_mod #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] max_val,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             co,
    output logic             done
);

    logic [WIDTH-1:0] q_nxt;
    logic             done_nxt;
    logic             at_top;

    // >= rather than == so an out-of-range value recovers on the next count
    assign at_top = (q >= max_val);

    always_comb begin
        q_nxt    = q;
        done_nxt = done;
        if (load) begin
            q_nxt    = din;
            done_nxt = 1'b0;
        end else if (done) begin
            q_nxt    = q;
        end else if (en) begin
            if (!at_top)
                q_nxt = q + WIDTH'(1);
            else if (one_shot)
                done_nxt = 1'b1;
            else
                q_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge clr or posedge pre) begin
        if (clr) begin
            q    <= '0;
            done <= 1'b0;
        end else if (pre) begin
            q    <= '1;
            done <= 1'b0;
        end else begin
            q    <= q_nxt;
            done <= done_nxt;
        end
    end

    assign qbar = ~q;
    assign tc   = (q == max_val);
    assign co   = tc & en & ~load & ~done;

endmodule

// File: tb/tb_syn_up_mod.sv
// Scoreboard bench for syn_up_mod: stimulus queues expected outputs,
// a monitor process pops and compares them against the live DUT.
module tb_syn_up_mod;

    typedef struct {
        string      nm;
        bit         sel;
        logic [7:0] q;
        logic       tc;
        logic       co;
        logic       done;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    logic       clk = 1'b0;
    logic       clr, pre, en, load, one_shot;
    logic [3:0] din, max_val;
    logic [3:0] q, qbar;
    logic       tc, co, done;

    logic       clr_c;
    logic [3:0] lo_q, lo_qbar, hi_q, hi_qbar;
    logic       lo_tc, lo_co, lo_done, hi_tc, hi_co, hi_done;

    always #5 clk = ~clk;

    syn_up_mod #(.WIDTH(4)) dut (
        .clk(clk), .clr(clr), .pre(pre), .en(en), .load(load),
        .din(din), .max_val(max_val), .one_shot(one_shot),
        .q(q), .qbar(qbar), .tc(tc), .co(co), .done(done)
    );

    syn_up_mod #(.WIDTH(4)) lo (
        .clk(clk), .clr(clr_c), .pre(1'b0), .en(1'b1), .load(1'b0),
        .din(4'd0), .max_val(4'd9), .one_shot(1'b0),
        .q(lo_q), .qbar(lo_qbar), .tc(lo_tc), .co(lo_co), .done(lo_done)
    );

    syn_up_mod #(.WIDTH(4)) hi (
        .clk(clk), .clr(clr_c), .pre(1'b0), .en(lo_co), .load(1'b0),
        .din(4'd0), .max_val(4'd9), .one_shot(1'b0),
        .q(hi_q), .qbar(hi_qbar), .tc(hi_tc), .co(hi_co), .done(hi_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] eq,
                       input logic etc, input logic eco, input logic edone);
        exp_t e;
        #1;
        e.nm = nm; e.sel = 1'b0; e.q = {4'd0, eq};
        e.tc = etc; e.co = eco; e.done = edone;
        sb.push_back(e);
        ->chk_ev;
        #1;
    endtask

    task automatic chk_c(input string nm, input logic [7:0] eq);
        exp_t e;
        #1;
        e.nm = nm; e.sel = 1'b1; e.q = eq;
        e.tc = 1'b0; e.co = 1'b0; e.done = 1'b0;
        sb.push_back(e);
        ->chk_ev;
        #1;
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (e.sel) begin
                    if ({hi_q, lo_q} !== e.q) begin
                        errors++;
                        $display("FAIL %s: hi:lo got %h want %h",
                                 e.nm, {hi_q, lo_q}, e.q);
                    end
                end else if (q !== e.q[3:0] || qbar !== ~e.q[3:0] ||
                             tc !== e.tc || co !== e.co ||
                             done !== e.done) begin
                    errors++;
                    $display("FAIL %s: got q=%h qbar=%h tc=%b co=%b done=%b want q=%h qbar=%h tc=%b co=%b done=%b",
                             e.nm, q, qbar, tc, co, done,
                             e.q[3:0], ~e.q[3:0], e.tc, e.co, e.done);
                end
            end
        end
    end

    initial begin
        logic [3:0] ev;
        logic       t;
        clr = 1; pre = 0; en = 0; load = 0; din = 0;
        max_val = 4'd9; one_shot = 0; clr_c = 1;
        #2;
        chk("reset", 4'd0, 0, 0, 0);
        max_val = 4'd0;
        chk("reset_tc_max0", 4'd0, 1, 0, 0);
        en = 1;
        chk("reset_co_max0", 4'd0, 1, 1, 0);
        en = 0; max_val = 4'd9;
        clr = 0; en = 1;
        chk("wrap_start", 4'd0, 0, 0, 0);
        for (int i = 1; i <= 11; i++) begin
            tick();
            ev = 4'(i % 10);
            t = (ev == 4'd9);
            chk($sformatf("wrap_%0d", i), ev, t, t, 0);
        end

        en = 0; load = 1; din = 4'd0;
        tick();
        load = 0;
        chk("os_load0", 4'd0, 0, 0, 0);
        max_val = 4'd5; one_shot = 1; en = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            t = (i == 5);
            chk($sformatf("os_cnt_%0d", i), 4'(i), t, t, 0);
        end
        tick();
        chk("os_done", 4'd5, 1, 0, 1);
        repeat (10) tick();
        chk("os_hold10", 4'd5, 1, 0, 1);
        load = 1; din = 4'd2;
        tick();
        load = 0;
        chk("os_reload", 4'd2, 0, 0, 0);

        en = 0; load = 1; din = 4'd3;
        tick();
        chk("pri_q3", 4'd3, 0, 0, 0);
        max_val = 4'd15; en = 1; din = 4'd12;
        tick();
        chk("pri_load_wins", 4'd12, 0, 0, 0);
        load = 0; en = 0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("pri_hold_%0d", i), 4'd12, 0, 0, 0);
        end

        max_val = 4'd6; one_shot = 0; load = 1; din = 4'd11;
        tick();
        load = 0; en = 1;
        chk("oor_11_no_tc", 4'd11, 0, 0, 0);
        tick();
        chk("oor_wrap", 4'd0, 0, 0, 0);
        tick();
        chk("oor_count", 4'd1, 0, 0, 0);

        en = 0; load = 1; din = 4'd0;
        tick();
        load = 0; max_val = 4'd0; en = 1;
        chk("m0_tc", 4'd0, 1, 1, 0);
        tick();
        chk("m0_wrap", 4'd0, 1, 1, 0);
        one_shot = 1;
        tick();
        chk("m0_os_done", 4'd0, 1, 0, 1);
        one_shot = 0;
        tick();
        chk("m0_sticky", 4'd0, 1, 0, 1);
        en = 0; pre = 1;
        chk("pre_clears_done", 4'd15, 0, 0, 0);
        pre = 0;

        max_val = 4'd9; load = 1; din = 4'd4;
        tick();
        load = 0; en = 1;
        chk("async_q4", 4'd4, 0, 0, 0);
        pre = 1;
        chk("async_pre", 4'd15, 0, 0, 0);
        clr = 1;
        chk("async_clr_wins", 4'd0, 0, 0, 0);
        pre = 0; clr = 0;
        tick();
        chk("resume_1", 4'd1, 0, 0, 0);
        tick();
        chk("resume_2", 4'd2, 0, 0, 0);

        clr_c = 0;
        repeat (37) tick();
        chk_c("cascade_37", 8'h37);
        repeat (63) tick();
        chk_c("cascade_100", 8'h00);

        repeat (5) #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
